// File: rtl/udp_rx_parser.sv
// UDP receive parser: pops bytes from the router's UDP FIFO, checks the 8-byte header,
// filters on destination port and streams the payload out with header sideband.
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | waiting for the router to hold a complete packet
// ST_HDR     | popping header bytes 0-7 (src, dst, len, checksum)
// ST_PAYLOAD | zero-latency payload pass-through under downstream ready
// ST_DROP    | discarding the remainder of a rejected packet

module udp_rx_parser #(
   parameter logic [15:0] P_UDP_PORT    = 16'd5000,
   parameter bit          P_PORT_FILTER = 1'b1,
   parameter int          P_CNT_W       = 16
) (
   input  logic               i_rxmac_clk,
   input  logic               i_rxmac_srst,
   input  logic               i_udp_pkt_byte_rdy,
   input  logic [7:0]         i_udp_pkt_byte,
   input  logic               i_udp_pkt_byte_vld,
   input  logic               i_udp_pkt_last_byte,
   output logic               o_udp_pkt_byte_rd,
   output logic [7:0]         o_payload_byte,
   output logic               o_payload_byte_vld,
   output logic               o_payload_last_byte,
   input  logic               i_payload_byte_rdy,
   output logic               o_hdr_vld,
   output logic [15:0]        o_src_port,
   output logic [15:0]        o_dst_port,
   output logic [15:0]        o_udp_len,
   output logic               o_runt_err,
   output logic               o_len_err,
   output logic               o_port_drop,
   output logic [P_CNT_W-1:0] o_pkt_cnt,
   output logic [P_CNT_W-1:0] o_drop_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HDR     = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_DROP    = 2'd3
   } state_t;

   localparam logic [P_CNT_W-1:0] CNT_MAX = '1;

   state_t      state, state_nxt;
   logic [2:0]  hdr_idx;
   logic [15:0] src_sh, dst_sh, len_sh;
   logic [15:0] pay_cnt;
   logic        hdr_xfer;
   logic        runt_set, len_set, port_set, hdr_set, pkt_inc, drop_inc;

   assign hdr_xfer = (state == ST_HDR) && i_udp_pkt_byte_vld;

   always_comb begin
      state_nxt           = state;
      o_udp_pkt_byte_rd   = 1'b0;
      o_payload_byte      = 8'h00;
      o_payload_byte_vld  = 1'b0;
      o_payload_last_byte = 1'b0;
      runt_set            = 1'b0;
      len_set             = 1'b0;
      port_set            = 1'b0;
      hdr_set             = 1'b0;
      pkt_inc             = 1'b0;
      drop_inc            = 1'b0;
      case (state)
         ST_IDLE: begin
            if (i_udp_pkt_byte_rdy) state_nxt = ST_HDR;
         end
         ST_HDR: begin
            o_udp_pkt_byte_rd = i_udp_pkt_byte_vld;
            if (i_udp_pkt_byte_vld) begin
               if (hdr_idx != 3'd7) begin
                  if (i_udp_pkt_last_byte) begin
                     runt_set  = 1'b1;
                     drop_inc  = 1'b1;
                     state_nxt = ST_IDLE;
                  end
               end else if (len_sh < 16'd8) begin
                  len_set   = 1'b1;
                  drop_inc  = 1'b1;
                  state_nxt = i_udp_pkt_last_byte ? ST_IDLE : ST_DROP;
               end else if (P_PORT_FILTER && (dst_sh != P_UDP_PORT)) begin
                  port_set  = 1'b1;
                  drop_inc  = 1'b1;
                  state_nxt = i_udp_pkt_last_byte ? ST_IDLE : ST_DROP;
               end else begin
                  hdr_set = 1'b1;
                  pkt_inc = 1'b1;
                  if (i_udp_pkt_last_byte) begin
                     len_set   = (len_sh != 16'd8);
                     state_nxt = ST_IDLE;
                  end else begin
                     state_nxt = ST_PAYLOAD;
                  end
               end
            end
         end
         ST_PAYLOAD: begin
            o_payload_byte      = i_udp_pkt_byte;
            o_payload_byte_vld  = i_udp_pkt_byte_vld;
            o_payload_last_byte = i_udp_pkt_last_byte;
            o_udp_pkt_byte_rd   = i_udp_pkt_byte_vld && i_payload_byte_rdy;
            if (o_udp_pkt_byte_rd && i_udp_pkt_last_byte) begin
               // len >= 8 is guaranteed here, so len-8 cannot wrap
               len_set   = ((pay_cnt + 16'd1) != (o_udp_len - 16'd8));
               state_nxt = ST_IDLE;
            end
         end
         ST_DROP: begin
            o_udp_pkt_byte_rd = i_udp_pkt_byte_vld;
            if (i_udp_pkt_byte_vld && i_udp_pkt_last_byte) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_rxmac_clk) begin
      if (i_rxmac_srst) begin
         state       <= ST_IDLE;
         hdr_idx     <= 3'd0;
         src_sh      <= 16'h0000;
         dst_sh      <= 16'h0000;
         len_sh      <= 16'h0000;
         pay_cnt     <= 16'h0000;
         o_hdr_vld   <= 1'b0;
         o_runt_err  <= 1'b0;
         o_len_err   <= 1'b0;
         o_port_drop <= 1'b0;
         o_src_port  <= 16'h0000;
         o_dst_port  <= 16'h0000;
         o_udp_len   <= 16'h0000;
         o_pkt_cnt   <= '0;
         o_drop_cnt  <= '0;
      end else begin
         state       <= state_nxt;
         o_hdr_vld   <= hdr_set;
         o_runt_err  <= runt_set;
         o_len_err   <= len_set;
         o_port_drop <= port_set;

         if (state == ST_IDLE) hdr_idx <= 3'd0;
         else if (hdr_xfer)    hdr_idx <= hdr_idx + 3'd1;

         if (hdr_xfer) begin
            case (hdr_idx)
               3'd0:    src_sh[15:8] <= i_udp_pkt_byte;
               3'd1:    src_sh[7:0]  <= i_udp_pkt_byte;
               3'd2:    dst_sh[15:8] <= i_udp_pkt_byte;
               3'd3:    dst_sh[7:0]  <= i_udp_pkt_byte;
               3'd4:    len_sh[15:8] <= i_udp_pkt_byte;
               3'd5:    len_sh[7:0]  <= i_udp_pkt_byte;
               default: ;
            endcase
         end

         // sideband only moves on an accepted header so it stays stable between pulses
         if (hdr_set) begin
            o_src_port <= src_sh;
            o_dst_port <= dst_sh;
            o_udp_len  <= len_sh;
         end

         if (state != ST_PAYLOAD)    pay_cnt <= 16'h0000;
         else if (o_udp_pkt_byte_rd) pay_cnt <= pay_cnt + 16'd1;

         if (pkt_inc && (o_pkt_cnt != CNT_MAX))   o_pkt_cnt  <= o_pkt_cnt + P_CNT_W'(1);
         if (drop_inc && (o_drop_cnt != CNT_MAX)) o_drop_cnt <= o_drop_cnt + P_CNT_W'(1);
      end
   end

endmodule

// File: doc/udp_rx_parser.md
Name: udp_rx_parser

Overview:
- Downstream consumer of the UDP output of ipv4_pkt_router in the gbit_mac receive path.
- Pulls UDP packet bytes from the router's UDP FIFO using the read-strobe interface. The router has already stripped the IPv4 header, so the first byte is UDP source port MSB.
- Parses and checks the 8-byte UDP header, filters on destination port, and forwards payload bytes on a valid/ready stream with header sideband and error/statistics outputs.

Parameters:
- P_UDP_PORT, 16'd5000, destination port accepted when filtering is enabled.
- P_PORT_FILTER, 1, 1 = drop packets whose destination port is not P_UDP_PORT; 0 = accept all ports.
- P_CNT_W, 16, width of the packet and drop statistics counters.

Ports:
- i_rxmac_clk  in  1  receive MAC clock.
- i_rxmac_srst  in  1  synchronous, active-high reset.
- i_udp_pkt_byte_rdy  in  1  router holds at least one complete UDP packet.
- i_udp_pkt_byte  in  8  current byte (first-word-fall-through).
- i_udp_pkt_byte_vld  in  1  i_udp_pkt_byte is valid.
- i_udp_pkt_last_byte  in  1  current byte is the last byte of its packet.
- o_udp_pkt_byte_rd  out  1  pop the current byte this cycle.
- o_payload_byte  out  8  payload data.
- o_payload_byte_vld  out  1  payload byte valid.
- o_payload_last_byte  out  1  last payload byte of the packet.
- i_payload_byte_rdy  in  1  downstream accepts the payload byte.
- o_hdr_vld  out  1  one-cycle pulse: header fields valid for the packet now starting.
- o_src_port  out  16  captured source port.
- o_dst_port  out  16  captured destination port.
- o_udp_len  out  16  captured UDP length field.
- o_runt_err  out  1  pulse: packet ended before 8 header bytes.
- o_len_err  out  1  pulse: length field < 8, or payload count ≠ length−8.
- o_port_drop  out  1  pulse: packet dropped by the port filter.
- o_pkt_cnt  out  P_CNT_W  accepted packets, saturating.
- o_drop_cnt  out  P_CNT_W  dropped or runt packets, saturating.

Behaviour:
- Reset:
  - State goes to IDLE.
  - All pulses, o_udp_pkt_byte_rd and o_payload_byte_vld are 0.
  - Header registers and counters are 0.
  - The router shares this reset, so no partial packet survives reset.
- Byte transfer rule: a byte transfers when o_udp_pkt_byte_rd=1 and i_udp_pkt_byte_vld=1 in the same cycle. o_udp_pkt_byte_rd is never asserted while i_udp_pkt_byte_vld=0.
- IDLE:
  - rd=0.
  - When i_udp_pkt_byte_rdy=1, go to HDR and clear the byte index.
- HDR:
  - rd=i_udp_pkt_byte_vld.
  - Bytes 0–7 are stored big-endian: src[15:8], src[7:0], dst, len, checksum (checksum is ignored).
  - Last byte at index < 7:
    - Pulse o_runt_err and increment o_drop_cnt.
    - Go to IDLE.
  - At index 7, checks in priority order:
    - len < 8: pulse o_len_err; drop (to DROP, or to IDLE if this byte is last); increment o_drop_cnt.
    - P_PORT_FILTER=1 and dst ≠ P_UDP_PORT: pulse o_port_drop; drop as above; increment o_drop_cnt.
    - Otherwise, on the cycle after byte 7: pulse o_hdr_vld (o_src_port, o_dst_port and o_udp_len are stable from this cycle until the next o_hdr_vld) and increment o_pkt_cnt.
    - If byte 7 is last (zero payload): go to IDLE, and pulse o_len_err if len ≠ 8.
    - Otherwise go to PAYLOAD.
- PAYLOAD:
  - Combinational pass-through, zero latency:
    - o_payload_byte = i_udp_pkt_byte.
    - o_payload_byte_vld = i_udp_pkt_byte_vld.
    - o_payload_last_byte = i_udp_pkt_last_byte.
    - o_udp_pkt_byte_rd = vld & i_payload_byte_rdy.
  - Count transferred payload bytes (16-bit).
  - On transfer of the last byte:
    - If count+1 ≠ len−8, pulse o_len_err one cycle later. The payload is still delivered.
    - Go to IDLE.
- DROP:
  - rd=i_udp_pkt_byte_vld; nothing is forwarded.
  - Go to IDLE after the last byte transfers.
- Outside PAYLOAD, o_payload_* = 0.
- Counters:
  - Saturate at all-ones.
  - A pulse and a counter increment caused by the same packet occur in the same cycle.
- Back-to-back packets:
  - One idle cycle in IDLE between packets.
  - Worst-case throughput is packet length + 1 cycles.

Test Plan:
- Accepted packet: dst=5000, len=12, payload DE AD BE EF, rdy held high → o_hdr_vld pulse with src/dst/len correct; 4 payload bytes with last on EF; o_pkt_cnt=1; no error pulses.
- Port filter: dst=5001 with P_PORT_FILTER=1 → o_port_drop pulse; no payload_vld; o_drop_cnt=1; all 12 bytes popped. Same packet with P_PORT_FILTER=0 → accepted.
- Backpressure: i_payload_byte_rdy toggled 1,0,0,1,… during payload → rd deasserts whenever rdy=0; byte order is preserved; no byte is lost or duplicated.
- Runt and length errors:
  - 5-byte packet → o_runt_err and o_drop_cnt increment.
  - len=6 → o_len_err and drop.
  - len=20 with 4 payload bytes → o_len_err after last; payload still delivered.
- Zero payload: len=8, 8-byte packet → o_hdr_vld, no payload_vld, o_pkt_cnt increments, no error. Two back-to-back packets → both parsed.
- Reset mid-payload: assert srst at payload byte 2 → all outputs 0 next cycle and state IDLE; the next clean packet parses normally. Counter saturation with P_CNT_W=2 → o_pkt_cnt holds at 3.
